// File: rtl/iob_eth_mii_tx_if.sv
// Bus bundle for the MII transmit engine.
// Groups the host start/status handshake, the TX buffer read port and the MII
// transmit outputs.
//   slave  : the transmit engine (iob_eth_mii_tx)
//   master : whoever drives the start request and the buffer read data
interface iob_eth_mii_tx_if #(
  parameter int unsigned BufAddrW = 9
);
  logic                send;      // start request
  logic [10:0]         nbytes;    // payload byte count, excluding FCS
  logic                busy;      // frame in progress, preamble through IFG
  logic                done;      // one-cycle pulse on the last IFG cycle
  logic [BufAddrW-1:0] buf_addr;  // TX buffer word address
  logic [31:0]         buf_data;  // TX buffer read data, 1-cycle latency
  logic [3:0]          tx_data;   // MII TX_DATA
  logic                tx_en;     // MII TX_EN

  modport slave (
    input  send, nbytes, buf_data,
    output busy, done, buf_addr, tx_data, tx_en
  );

  modport master (
    output send, nbytes, buf_data,
    input  busy, done, buf_addr, tx_data, tx_en
  );
endinterface

// File: rtl/iob_eth_mii_tx.sv
// MII transmit engine.
// Reads a frame from the TX buffer (32-bit words, 1-cycle read latency) and
// sends it as MII nibbles: preamble + SFD, payload, zero padding up to
// MinFrame bytes, CRC-32 FCS, then IfgCyc idle cycles.
// Ports:
//   clk_i  : MII TX clock, all logic on the rising edge
//   rst_ni : asynchronous active-low reset
//   tx_if  : slave side of iob_eth_mii_tx_if (send/nbytes/busy/done, buffer
//            address/data, tx_data/tx_en)
module iob_eth_mii_tx #(
  parameter int unsigned BufAddrW = 9,
  parameter int unsigned MinFrame = 60,
  parameter int unsigned IfgCyc   = 24
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  iob_eth_mii_tx_if.slave tx_if
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StPre     = 3'd1;
  localparam logic [2:0] StPayload = 3'd2;
  localparam logic [2:0] StPad     = 3'd3;
  localparam logic [2:0] StFcs     = 3'd4;
  localparam logic [2:0] StIfg     = 3'd5;

  localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcPoly = 32'hEDB8_8320;
  localparam logic [11:0] MinNib  = 12'(2 * MinFrame);
  localparam logic [11:0] IfgLast = 12'(IfgCyc - 1);

  logic [2:0]          state_q, state_d;
  logic [11:0]         cnt_q, cnt_d;        // nibble / cycle index within the phase
  logic [10:0]         nbytes_q, nbytes_d;
  logic [27:0]         sh_q, sh_d;          // remaining nibbles of the current word
  logic [31:0]         crc_q, crc_d;
  logic [BufAddrW-1:0] addr_q, addr_d;
  logic [3:0]          tx_data_q, tx_data_d;
  logic                tx_en_q, tx_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Reflected CRC-32, one nibble (LSB first) per call.
  function automatic logic [31:0] crc_nib(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc ^ {28'd0, nib};
    for (int i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  logic [11:0] pay_nib;
  logic [11:0] tot_nib;
  logic [11:0] nib_idx;
  logic        in_payload;
  logic        word_start;
  logic [3:0]  data_nib;
  logic [31:0] fcs_all;
  logic [2:0]  fcs_sel;
  logic [3:0]  fcs_nib;

  // Index of the data nibble that will be driven after the next edge.
  assign pay_nib    = {nbytes_q, 1'b0};
  assign tot_nib    = (pay_nib > MinNib) ? pay_nib : MinNib;
  assign nib_idx    = (state_q == StPre) ? 12'd0 : cnt_q + 12'd1;
  assign in_payload = nib_idx < pay_nib;
  assign word_start = nib_idx[2:0] == 3'd0;
  // The first nibble of a word comes straight from the buffer read data; the
  // rest of the word is held in sh_q. Anything past the payload is padding.
  assign data_nib   = !in_payload ? 4'h0 :
                      word_start  ? tx_if.buf_data[3:0] : sh_q[3:0];

  assign fcs_all = ~crc_q;
  assign fcs_sel = (state_q == StFcs) ? cnt_q[2:0] + 3'd1 : 3'd0;
  assign fcs_nib = fcs_all[{fcs_sel, 2'b00} +: 4];

  always_comb begin
    logic go_data;
    logic go_fcs;
    state_d   = state_q;
    cnt_d     = cnt_q;
    nbytes_d  = nbytes_q;
    sh_d      = sh_q;
    crc_d     = crc_q;
    addr_d    = addr_q;
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    go_data   = 1'b0;
    go_fcs    = 1'b0;

    case (state_q)
      StIdle: begin
        tx_en_d   = 1'b0;
        tx_data_d = 4'h0;
        busy_d    = 1'b0;
        addr_d    = '0;
        if (tx_if.send) begin
          state_d   = StPre;
          cnt_d     = 12'd0;
          nbytes_d  = tx_if.nbytes;
          crc_d     = CrcInit;
          tx_en_d   = 1'b1;
          tx_data_d = 4'h5;
          busy_d    = 1'b1;
        end
      end
      StPre: begin
        if (cnt_q == 12'd15) begin
          go_data = tot_nib != 12'd0;
          go_fcs  = tot_nib == 12'd0;
        end else begin
          cnt_d     = cnt_q + 12'd1;
          tx_data_d = (cnt_q == 12'd14) ? 4'hD : 4'h5;
        end
      end
      StPayload, StPad: begin
        go_data = nib_idx != tot_nib;
        go_fcs  = nib_idx == tot_nib;
      end
      StFcs: begin
        if (cnt_q[2:0] == 3'd7) begin
          state_d   = StIfg;
          cnt_d     = 12'd0;
          tx_en_d   = 1'b0;
          tx_data_d = 4'h0;
          done_d    = IfgLast == 12'd0;
        end else begin
          cnt_d     = cnt_q + 12'd1;
          tx_data_d = fcs_nib;
        end
      end
      StIfg: begin
        if (cnt_q == IfgLast) begin
          state_d = StIdle;
          cnt_d   = 12'd0;
          busy_d  = 1'b0;
          addr_d  = '0;
          crc_d   = CrcInit;
        end else begin
          cnt_d  = cnt_q + 12'd1;
          done_d = (cnt_q + 12'd1) == IfgLast;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (go_data) begin
      state_d   = in_payload ? StPayload : StPad;
      cnt_d     = nib_idx;
      tx_data_d = data_nib;
      crc_d     = crc_nib(crc_q, data_nib);
      if (in_payload) begin
        if (word_start) begin
          // Next word's address goes out as this word starts: it then has a
          // full word time to settle before it is sampled.
          sh_d   = tx_if.buf_data[31:4];
          addr_d = addr_q + 1'b1;
        end else begin
          sh_d = sh_q >> 4;
        end
      end
    end

    if (go_fcs) begin
      state_d   = StFcs;
      cnt_d     = 12'd0;
      tx_data_d = fcs_nib;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= 12'd0;
      nbytes_q  <= 11'd0;
      sh_q      <= 28'd0;
      crc_q     <= CrcInit;
      addr_q    <= '0;
      tx_data_q <= 4'h0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nbytes_q  <= nbytes_d;
      sh_q      <= sh_d;
      crc_q     <= crc_d;
      addr_q    <= addr_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_if.busy     = busy_q;
  assign tx_if.done     = done_q;
  assign tx_if.buf_addr = addr_q;
  assign tx_if.tx_data  = tx_data_q;
  assign tx_if.tx_en    = tx_en_q;

endmodule

// File: tb/tb_iob_eth_mii_tx.sv
module tb_iob_eth_mii_tx;
  localparam int unsigned BufAddrW = 9;
  localparam int unsigned IfgCyc   = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // bus_a: default parameters (MinFrame 60); bus_b: padding disabled
  iob_eth_mii_tx_if #(.BufAddrW(BufAddrW)) bus_a ();
  iob_eth_mii_tx_if #(.BufAddrW(BufAddrW)) bus_b ();

  iob_eth_mii_tx #(.BufAddrW(BufAddrW)) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tx_if  (bus_a)
  );

  iob_eth_mii_tx #(.BufAddrW(BufAddrW), .MinFrame(0)) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tx_if  (bus_b)
  );

  logic [31:0] mem [2**BufAddrW];
  always @(posedge clk) begin
    bus_a.buf_data <= mem[bus_a.buf_addr];
    bus_b.buf_data <= mem[bus_b.buf_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic       sel;
  logic       mon_tx_en, mon_busy, mon_done;
  logic [3:0] mon_tx_data;
  always_comb begin
    mon_tx_en   = sel ? bus_b.tx_en   : bus_a.tx_en;
    mon_tx_data = sel ? bus_b.tx_data : bus_a.tx_data;
    mon_busy    = sel ? bus_b.busy    : bus_a.busy;
    mon_done    = sel ? bus_b.done    : bus_a.done;
  end

  logic [3:0] cap[$];
  logic [3:0] exp_q[$];
  int         ifg_len;
  bit         got_done;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic set_send(input logic s, input logic v);
    if (s) bus_b.send = v; else bus_a.send = v;
  endtask

  // Start one frame on the selected DUT and capture its nibbles until DONE.
  task automatic run_frame(input logic s, input int nb, input bit poke, input bit hold);
    sel = s;
    cap.delete();
    ifg_len  = 0;
    got_done = 0;
    @(negedge clk);
    if (s) bus_b.nbytes = 11'(nb); else bus_a.nbytes = 11'(nb);
    set_send(s, 1'b1);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (mon_tx_en) cap.push_back(mon_tx_data);
      else if (mon_busy) ifg_len++;
      set_send(s, hold || (poke && (cap.size() == 40 || ifg_len == 5)));
      if (mon_done) begin
        got_done = 1;
        break;
      end
    end
  endtask

  // Compare the captured frame against the expected nibble stream.
  task automatic verify(input string tag, input int nb, input int minf);
    int          tot;
    int          errs;
    logic [31:0] crc;
    logic [31:0] res;
    logic [7:0]  b;
    tot = (nb > minf) ? nb : minf;
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < tot; i++) begin
      logic [31:0] w;
      w = mem[(i / 4) % (2**BufAddrW)];
      b = (i < nb) ? w[8*(i%4) +: 8] : 8'h00;
      crc = crc_byte(crc, b);
      exp_q.push_back(b[3:0]);
      exp_q.push_back(b[7:4]);
    end
    crc = ~crc;
    for (int i = 0; i < 8; i++) exp_q.push_back(crc[4*i +: 4]);
    errs = 0;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) errs++;
    check({tag, "_len"}, cap.size(), exp_q.size());
    check({tag, "_nib_errs"}, errs, 0);
    check({tag, "_done"}, {31'd0, got_done}, 1);
    check({tag, "_ifg"}, ifg_len, IfgCyc);
    res = 32'hFFFFFFFF;
    for (int i = 16; i + 1 < cap.size(); i += 2) res = crc_byte(res, {cap[i+1], cap[i]});
    check({tag, "_residue"}, res, 32'hDEBB20E3);
  endtask

  function automatic logic [31:0] cap_fcs();
    logic [31:0] f;
    f = 32'd0;
    if (cap.size() >= 8)
      for (int i = 0; i < 8; i++) f[4*i +: 4] = cap[cap.size() - 8 + i];
    return f;
  endfunction

  initial begin
    int gap;
    int busy_cnt;
    rst_n = 1'b1;
    bus_a.send = 1'b0; bus_a.nbytes = 11'd0;
    bus_b.send = 1'b0; bus_b.nbytes = 11'd0;
    sel = 1'b0;
    for (int i = 0; i < 2**BufAddrW; i++) mem[i] = $urandom;
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_en", {31'd0, bus_a.tx_en}, 0);
    check("rst_tx_data", {28'd0, bus_a.tx_data}, 0);
    check("rst_busy", {31'd0, bus_a.busy}, 0);
    check("rst_done", {31'd0, bus_a.done}, 0);
    check("rst_addr", {23'd0, bus_a.buf_addr}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // "123456789", upper bytes of word 2 must be ignored
    mem[0] = 32'h34333231;
    mem[1] = 32'h38373635;
    mem[2] = 32'hAABBCC39;
    run_frame(1'b1, 9, 0, 0);
    verify("crc9", 9, 0);
    check("crc9_fcs", cap_fcs(), 32'hCBF43926);
    check("crc9_first_pay", (cap.size() > 17) ? {24'd0, cap[17], cap[16]} : 32'hX, 32'h31);

    // empty frame, no padding: preamble + all-zero FCS
    run_frame(1'b1, 0, 0, 0);
    verify("empty", 0, 0);
    check("empty_fcs", cap_fcs(), 32'h0);

    // short frame padded to 60 bytes
    run_frame(1'b0, 14, 0, 0);
    verify("pad14", 14, 60);

    // maximum-size frame, random data
    for (int i = 0; i < 2**BufAddrW; i++) mem[i] = $urandom;
    run_frame(1'b0, 1514, 0, 0);
    verify("max1514", 1514, 60);
    check("max1514_len_abs", cap.size(), 3052);

    // SEND pulses during payload and IFG are ignored
    run_frame(1'b0, 20, 1, 0);
    verify("poke", 20, 60);
    busy_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_a.busy) busy_cnt++;
    end
    check("poke_no_second", busy_cnt, 0);

    // SEND held across DONE: next frame starts after one idle cycle
    run_frame(1'b0, 10, 0, 1);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_a.busy) break;
      gap++;
    end
    check("hold_gap", gap, 1);
    bus_a.send = 1'b0;
    got_done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus_a.done) begin
        got_done = 1;
        break;
      end
    end
    check("hold_done2", {31'd0, got_done}, 1);

    // reset in the middle of the payload
    @(negedge clk);
    bus_a.nbytes = 11'd40;
    bus_a.send   = 1'b1;
    @(negedge clk);
    bus_a.send = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_tx_en_before", {31'd0, bus_a.tx_en}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_tx_en", {31'd0, bus_a.tx_en}, 0);
    check("mid_busy", {31'd0, bus_a.busy}, 0);
    check("mid_addr", {23'd0, bus_a.buf_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b0, 60, 0, 0);
    verify("after_rst", 60, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
